// File: rtl/cordic_atan_input_conditioner.sv
// Folds (x, y) into the right half-plane and pre-scales it ahead of the CORDIC arctangent core.
// Optional macro CORDIC_COND_STATS_EN adds saturating fold/saturation event counters.
module cordic_atan_input_conditioner #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = 16,
    parameter int unsigned GUARD_BITS = 2
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_x,
    input  logic [DATA_WIDTH-1:0]             in_y,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_x,
    output logic [DATA_WIDTH-1:0]             out_y,
    output logic [DATA_WIDTH-1:0]             out_z_offset,
    output logic [$clog2(GUARD_BITS+1)-1:0]   out_scale,
    output logic                              out_zero,
    output logic                              out_sat
`ifdef CORDIC_COND_STATS_EN
    ,
    output logic [15:0]                       stat_fold_cnt,
    output logic [15:0]                       stat_sat_cnt
`endif
);

    localparam int unsigned SW = $clog2(GUARD_BITS + 1);

    localparam logic [DATA_WIDTH-1:0] MaxPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] Ang90  = DATA_WIDTH'(90) << FRAC_BITS;
    localparam logic [DATA_WIDTH-1:0] AngM90 = -Ang90;
    localparam logic [DATA_WIDTH-1:0] Limit  = DATA_WIDTH'(1) << (DATA_WIDTH - 1 - GUARD_BITS);

    logic                          s1_valid_q;
    logic signed [DATA_WIDTH-1:0]  s1_x_q, s1_y_q;
    logic [DATA_WIDTH-1:0]         s1_z_q;
    logic                          s1_zero_q, s1_sat_q;
    logic                          s1_move;

    logic signed [DATA_WIDTH-1:0]  f_x, f_y;
    logic [DATA_WIDTH-1:0]         f_z;
    logic                          f_zero, f_sat;

    logic [DATA_WIDTH-1:0]         mag_x, mag_y, mag_max;
    logic [SW-1:0]                 sc;
    logic signed [DATA_WIDTH-1:0]  sh_x, sh_y;

    assign s1_move  = !out_valid || out_ready;
    assign in_ready = !s1_valid_q || s1_move;

    // Fold: rotate left-half-plane vectors by -/+90 deg; negating the minimum clamps to MaxPos.
    always_comb begin
        f_x    = in_x;
        f_y    = in_y;
        f_z    = '0;
        f_sat  = 1'b0;
        f_zero = (in_x == '0) && (in_y == '0);
        if (in_x[DATA_WIDTH-1]) begin
            if (!in_y[DATA_WIDTH-1]) begin
                f_x   = in_y;
                f_y   = (in_x == MinNeg) ? MaxPos : -in_x;
                f_sat = (in_x == MinNeg);
                f_z   = Ang90;
            end else begin
                f_x   = (in_y == MinNeg) ? MaxPos : -in_y;
                f_y   = in_x;
                f_sat = (in_y == MinNeg);
                f_z   = AngM90;
            end
        end
    end

    // Magnitudes are unsigned so that |MinNeg| is represented exactly.
    always_comb begin
        mag_x   = s1_x_q[DATA_WIDTH-1] ? -s1_x_q : s1_x_q;
        mag_y   = s1_y_q[DATA_WIDTH-1] ? -s1_y_q : s1_y_q;
        mag_max = (mag_x > mag_y) ? mag_x : mag_y;
        sc      = SW'(GUARD_BITS);
        for (int i = GUARD_BITS; i >= 0; i--) begin
            if ((mag_max >> i) < Limit) begin
                sc = SW'(i);
            end
        end
        sh_x = s1_x_q >>> sc;
        sh_y = s1_y_q >>> sc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_z_q       <= '0;
            s1_zero_q    <= 1'b0;
            s1_sat_q     <= 1'b0;
            out_valid    <= 1'b0;
            out_x        <= '0;
            out_y        <= '0;
            out_z_offset <= '0;
            out_scale    <= '0;
            out_zero     <= 1'b0;
            out_sat      <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_x_q    <= f_x;
                s1_y_q    <= f_y;
                s1_z_q    <= f_z;
                s1_zero_q <= f_zero;
                s1_sat_q  <= f_sat;
            end
            if (s1_move) begin
                out_valid <= s1_valid_q;
                if (s1_valid_q) begin
                    out_x        <= sh_x;
                    out_y        <= sh_y;
                    out_z_offset <= s1_z_q;
                    out_scale    <= sc;
                    out_zero     <= s1_zero_q;
                    out_sat      <= s1_sat_q;
                end
            end
        end
    end

`ifdef CORDIC_COND_STATS_EN
    logic out_fire;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_fold_cnt <= '0;
            stat_sat_cnt  <= '0;
        end else begin
            if (out_fire && (out_z_offset != '0) && (stat_fold_cnt != 16'hFFFF)) begin
                stat_fold_cnt <= stat_fold_cnt + 16'd1;
            end
            if (out_fire && out_sat && (stat_sat_cnt != 16'hFFFF)) begin
                stat_sat_cnt <= stat_sat_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/cordic_atan_input_conditioner.md
Name: cordic_atan_input_conditioner

Overview:
- Upstream stage feeding the CORDIC arctangent core; accepts raw signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS (x, y) vectors over a valid/ready handshake.
- Folds the vector into the right half-plane and reports the matching ±90° angle offset (Q16.16 degrees, the core's angle format).
- Pre-scales both components by a right shift so the CORDIC gain (~1.647) cannot overflow.
- Two-stage registered pipeline with full-throughput backpressure.

Parameters:
- DATA_WIDTH, 32, width of x/y/angle words (two's complement).
- FRAC_BITS, 16, fractional bits of x/y and of the angle offset (degrees).
- GUARD_BITS, 2, headroom bits; folded |x|,|y| must be < 2^(DATA_WIDTH-1-GUARD_BITS) at output.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  stage 1 can accept.
- in_x  in  DATA_WIDTH  signed x.
- in_y  in  DATA_WIDTH  signed y.
- out_valid  out  1  conditioned vector valid.
- out_ready  in  1  CORDIC core accepts.
- out_x  out  DATA_WIDTH  folded, scaled x (always >= 0).
- out_y  out  DATA_WIDTH  folded, scaled y.
- out_z_offset  out  DATA_WIDTH  angle to add to the core result: 0, +90° (0x005A0000) or -90° (0xFFA60000).
- out_scale  out  $clog2(GUARD_BITS+1)  right-shift amount applied.
- out_zero  out  1  input was (0,0); angle undefined, downstream forces 0.
- out_sat  out  1  a negation saturated (input held the most-negative value).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, named resetn.
- Reset: all valid flags 0; out_x, out_y, out_z_offset, out_scale, out_zero and out_sat are 0; in_ready is 1 once reset deasserts.
- Handshake:
  - A transfer occurs on a rising edge with valid && ready.
  - in_ready = !s1_valid || s1_move, where s1_move = !s2_valid || out_ready.
  - Output registers hold stable while out_valid && !out_ready.
  - in_ready must not depend combinationally on in_valid.
- Latency: 2 cycles from input transfer to out_valid when unstalled; 1 vector/cycle sustained with out_ready held high.
- Stage 1 (fold), registered:
  - x >= 0: pass through, z_off = 0.
  - x < 0, y >= 0: x' = y, y' = -x, z_off = +90°.
  - x < 0, y < 0: x' = -y, y' = x, z_off = -90°.
  - Negating the most-negative value yields 2^(DATA_WIDTH-1)-1 and sets sat.
  - zero = (x == 0 && y == 0); a zero input still propagates with z_off = 0.
- Stage 2 (scale), registered:
  - m = max(|x'|, |y'|); L = 2^(DATA_WIDTH-1-GUARD_BITS).
  - s = smallest value in 0..GUARD_BITS with (m >>> s) < L.
  - out_x = x' >>> s, out_y = y' >>> s (arithmetic shift, truncating); out_scale = s.
  - z_offset, zero and sat pass through unchanged.
- Simultaneous accept on both sides with s2 full and out_ready=1: s2 loads from s1 and s1 loads from input on the same edge; no bubble, no loss.
- Reset asserted mid-stream: in-flight vectors are discarded; the next output comes only from a vector accepted after reset release.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro CORDIC_COND_STATS_EN.
- Defined:
  - Adds outputs stat_fold_cnt[15:0] and stat_sat_cnt[15:0].
  - Counters increment on each output transfer with z_offset != 0, and with out_sat = 1, respectively.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Test Plan:
- x=0xFFFF0000 (-1.0), y=0x00008000 (0.5), out_ready=1 -> 2 cycles later: out_x=0x00008000, out_y=0x00010000, z_offset=0x005A0000, scale=0, sat=0, zero=0.
- x=0xFFFF0000, y=0xFFFF0000 -> out_x=0x00010000, out_y=0xFFFF0000, z_offset=0xFFA60000.
- x=0x40000000, y=0 -> out_x=0x10000000, out_y=0, scale=2, z_offset=0.
- x=0x80000000, y=0 -> out_x=0, out_y=0x1FFFFFFF, z_offset=0x005A0000, scale=2, sat=1.
- Backpressure and zero input:
  - Send 5 back-to-back vectors with out_ready low for cycles 3-6: all 5 delivered in order, unduplicated, outputs stable while stalled, in_ready low only when both stages are full.
  - x=y=0 -> out_zero=1, out_x=out_y=0, z_offset=0.
- Reset mid-stream:
  - Assert resetn=0 with 2 vectors in flight -> out_valid=0 immediately, in_ready=1 after release, no stale vector emitted.
  - With CORDIC_COND_STATS_EN defined, counters read 0 after reset.
